// File: rtl/ysyx_23060077_regfile_mp.sv
// ysyx_23060077_regfile_mp
//   Multi-port general-purpose register file for the pipelined core, with a
//   per-register busy scoreboard. Decode reads operands and marks destinations
//   busy on issue. Writeback writes results and clears the matching busy bit.
//   An optional bypass lets a read see the value being written back in the
//   same cycle. x0 always reads as zero and is never busy.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous reset, active-low
//   rs_addr   read addresses, port k = [k*REG_WIDTH +: REG_WIDTH]
//   rs_data   read data, port k = [k*DATA_WIDTH +: DATA_WIDTH] (combinational)
//   rs_busy   per read port: register has an unresolved pending write
//   iss_en    issue strobe: mark iss_addr busy
//   iss_addr  destination register of the issued instruction
//   rd_en     write enable per write port
//   rd_addr   write address per write port
//   rd_data   write data per write port
//   busy_vec  current busy bits (bit 0 always 0)
module ysyx_23060077_regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int REG_WIDTH  = $clog2(REG_COUNT),
  parameter int NR_RD      = 2,
  parameter int NR_WR      = 1,
  parameter int BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NR_RD*REG_WIDTH-1:0]    rs_addr,
  output logic [NR_RD*DATA_WIDTH-1:0]   rs_data,
  output logic [NR_RD-1:0]              rs_busy,
  input  logic                          iss_en,
  input  logic [REG_WIDTH-1:0]          iss_addr,
  input  logic [NR_WR-1:0]              rd_en,
  input  logic [NR_WR*REG_WIDTH-1:0]    rd_addr,
  input  logic [NR_WR*DATA_WIDTH-1:0]   rd_data,
  output logic [REG_COUNT-1:0]          busy_vec
);

  logic [DATA_WIDTH-1:0] gpr [REG_COUNT];
  logic [REG_COUNT-1:0]  busy;
  logic [REG_COUNT-1:0]  busy_nxt;

  // Scoreboard next state. Writeback clears, issue sets; the issue is applied
  // last so a new producer issued in the same cycle as a writeback keeps the
  // register pending. Entry 0 is never busy.
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < REG_COUNT; r++) begin
      for (int j = 0; j < NR_WR; j++) begin
        if (rd_en[j] && (rd_addr[j*REG_WIDTH +: REG_WIDTH] == REG_WIDTH'(r))) begin
          busy_nxt[r] = 1'b0;
        end
      end
      if (iss_en && (iss_addr == REG_WIDTH'(r))) begin
        busy_nxt[r] = 1'b1;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Register array. x0 is never written so it stays at its reset value of 0.
  // Later write ports are visited last, so the highest port index wins on an
  // address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        gpr[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NR_WR; j++) begin
        if (rd_en[j] && (rd_addr[j*REG_WIDTH +: REG_WIDTH] != '0)) begin
          gpr[rd_addr[j*REG_WIDTH +: REG_WIDTH]] <= rd_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    logic [REG_WIDTH-1:0]  a;
    logic [DATA_WIDTH-1:0] d;
    logic                  b;
    rs_data = '0;
    rs_busy = '0;
    for (int k = 0; k < NR_RD; k++) begin
      a = rs_addr[k*REG_WIDTH +: REG_WIDTH];
      d = gpr[a];
      b = busy[a];
      if (BYPASS != 0) begin
        // A matching writeback resolves the pending write, so the read is
        // not busy unless a new producer for the same register issues now.
        for (int j = 0; j < NR_WR; j++) begin
          if (rd_en[j] && (rd_addr[j*REG_WIDTH +: REG_WIDTH] == a)) begin
            d = rd_data[j*DATA_WIDTH +: DATA_WIDTH];
            b = iss_en && (iss_addr == a);
          end
        end
      end
      // Gating with reset keeps bypass data and same-cycle issues from
      // leaking out while the block is held in reset.
      if ((a == '0) || !reset) begin
        d = '0;
        b = 1'b0;
      end
      rs_data[k*DATA_WIDTH +: DATA_WIDTH] = d;
      rs_busy[k] = b;
    end
  end

  assign busy_vec = busy;

endmodule
